// File: rtl/l1d_miss_pkg.sv
// l1d_miss_pkg: shared types for the L1D miss buffer.
// Holds the entry-state encoding and the default line-address width.
package l1d_miss_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ent_state_e;

  localparam int unsigned DEF_ADDR_W = 37;

endpackage

// File: rtl/l1d_miss_entry.sv
// l1d_miss_entry: one miss-buffer slot (state, line addr, store flag).
// Ports: alloc/merge/issue/resp/unlock controls in; per-port hit, state, addr, st out.
module l1d_miss_entry
  import l1d_miss_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PORTS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_i,
  input  logic [ADDR_W-1:0]       alloc_addr_i,
  input  logic                    alloc_st_i,
  input  logic                    merge_i,
  input  logic                    merge_st_i,
  input  logic                    issue_i,
  input  logic                    resp_i,
  input  logic                    unlock_i,
  input  logic [PORTS*ADDR_W-1:0] cmp_addr_i,
  output logic [PORTS-1:0]        hit_o,
  output ent_state_e              state_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic                    st_o
);

  ent_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              st_q, st_d;
  logic              st_mrg;

  always_comb begin
    hit_o = '0;
    for (int p = 0; p < PORTS; p++) begin
      hit_o[p] = (state_q != FREE) &&
                 (addr_q == cmp_addr_i[p*ADDR_W +: ADDR_W]);
    end
  end

  // merged store bit is visible the same cycle so an
  // issuing request carries the ownership need
  assign st_mrg = st_q | (merge_i & merge_st_i);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    st_d    = st_mrg;
    if (alloc_i) begin
      state_d = PEND;
      addr_d  = alloc_addr_i;
      st_d    = alloc_st_i;
    end else begin
      case (state_q)
        PEND:    if (issue_i)  state_d = WAIT;
        WAIT:    if (resp_i)   state_d = DONE;
        DONE:    if (unlock_i) state_d = FREE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      addr_q  <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      st_q    <= st_d;
    end
  end

  assign state_o = state_q;
  assign addr_o  = addr_q;
  assign st_o    = st_mrg;

endmodule

// File: rtl/l1d_miss_cam_gen.sv
// l1d_miss_cam_gen: multi-port L1D miss buffer with merge, L2 issue, replay/lock.
// Ports: fill_* (PORTS misses in, ack/match/tag out), req_* to L2, resp_*, free_cnt, locked, begin_replay, unlock.
module l1d_miss_cam_gen
  import l1d_miss_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PORTS   = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TAG_W   = $clog2(ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        fill_en_i,
  input  logic [PORTS*ADDR_W-1:0] fill_addr_i,
  input  logic [PORTS-1:0]        fill_st_i,
  output logic [PORTS-1:0]        fill_ack_o,
  output logic [PORTS-1:0]        fill_match_o,
  output logic [PORTS*TAG_W-1:0]  fill_tag_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ADDR_W-1:0]       req_addr_o,
  output logic [TAG_W-1:0]        req_tag_o,
  output logic                    req_st_o,
  input  logic                    resp_en_i,
  input  logic [TAG_W-1:0]        resp_tag_i,
  output logic [TAG_W:0]          free_cnt_o,
  output logic                    locked_o,
  output logic                    begin_replay_o,
  input  logic                    unlock_i
);

  logic [ENTRIES-1:0][PORTS-1:0]  hit;
  ent_state_e                     e_state [ENTRIES];
  logic [ENTRIES-1:0][ADDR_W-1:0] e_addr;
  logic [ENTRIES-1:0]             e_st;
  logic [ENTRIES-1:0]             alloc_e, alloc_st;
  logic [ENTRIES-1:0]             merge_e, merge_st;
  logic [ENTRIES-1:0]             issue_e, resp_e, taken;
  logic [ENTRIES-1:0][ADDR_W-1:0] alloc_addr;
  logic [PORTS-1:0][PORTS-1:0]    same;
  logic [PORTS-1:0][TAG_W-1:0]    tag;
  logic [PORTS-1:0]               p_alloc;
  logic                           fill_ok, full, found, busy;
  logic                           locked_q, locked_d;
  logic                           started_q, started_d;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    l1d_miss_entry #(
      .ADDR_W(ADDR_W),
      .PORTS (PORTS)
    ) u_ent (
      .clk         (clk),
      .rst         (rst),
      .alloc_i     (alloc_e[i]),
      .alloc_addr_i(alloc_addr[i]),
      .alloc_st_i  (alloc_st[i]),
      .merge_i     (merge_e[i]),
      .merge_st_i  (merge_st[i]),
      .issue_i     (issue_e[i]),
      .resp_i      (resp_e[i]),
      .unlock_i    (unlock_i),
      .cmp_addr_i  (fill_addr_i),
      .hit_o       (hit[i]),
      .state_o     (e_state[i]),
      .addr_o      (e_addr[i]),
      .st_o        (e_st[i])
    );
  end

  always_comb begin
    same = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        same[p][q] = fill_addr_i[p*ADDR_W +: ADDR_W] ==
                     fill_addr_i[q*ADDR_W +: ADDR_W];
      end
    end
  end

  // unlock cycle refuses fills even though lock drops next cycle
  assign fill_ok = !locked_q && !unlock_i;

  // ports in ascending order: live hit, then same-cycle
  // merge with a lower allocating port, then free slot
  always_comb begin
    fill_ack_o   = '0;
    fill_match_o = '0;
    tag          = '0;
    p_alloc      = '0;
    taken        = '0;
    alloc_e      = '0;
    alloc_st     = '0;
    alloc_addr   = '0;
    merge_e      = '0;
    merge_st     = '0;
    full         = 1'b0;
    found        = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      found = 1'b0;
      if (fill_en_i[p] && fill_ok) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!found && hit[i][p]) begin
            found           = 1'b1;
            fill_ack_o[p]   = 1'b1;
            fill_match_o[p] = 1'b1;
            tag[p]          = TAG_W'(i);
            merge_e[i]      = 1'b1;
            merge_st[i]     = merge_st[i] | fill_st_i[p];
          end
        end
        for (int q = 0; q < p; q++) begin
          if (!found && p_alloc[q] && same[p][q]) begin
            found              = 1'b1;
            fill_ack_o[p]      = 1'b1;
            fill_match_o[p]    = 1'b1;
            tag[p]             = tag[q];
            alloc_st[tag[q]]   = alloc_st[tag[q]] | fill_st_i[p];
          end
        end
        for (int i = 0; i < ENTRIES; i++) begin
          if (!found && e_state[i] == FREE && !taken[i]) begin
            found         = 1'b1;
            fill_ack_o[p] = 1'b1;
            tag[p]        = TAG_W'(i);
            taken[i]      = 1'b1;
            p_alloc[p]    = 1'b1;
            alloc_e[i]    = 1'b1;
            alloc_addr[i] = fill_addr_i[p*ADDR_W +: ADDR_W];
            alloc_st[i]   = fill_st_i[p];
          end
        end
        if (!found) full = 1'b1;
      end
    end
  end

  always_comb begin
    fill_tag_o = '0;
    for (int p = 0; p < PORTS; p++) begin
      fill_tag_o[p*TAG_W +: TAG_W] = tag[p];
    end
  end

  always_comb begin
    req_valid_o = 1'b0;
    req_tag_o   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (e_state[i] == PEND) begin
        req_valid_o = 1'b1;
        req_tag_o   = TAG_W'(i);
      end
    end
  end

  assign req_addr_o = e_addr[req_tag_o];
  assign req_st_o   = e_st[req_tag_o];

  always_comb begin
    issue_e    = '0;
    resp_e     = '0;
    busy       = 1'b0;
    free_cnt_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      issue_e[i] = req_valid_o && req_ready_i &&
                   (req_tag_o == TAG_W'(i));
      resp_e[i]  = resp_en_i && (resp_tag_i == TAG_W'(i));
      if (e_state[i] == PEND || e_state[i] == WAIT) busy = 1'b1;
      if (e_state[i] == FREE) free_cnt_o = free_cnt_o + (TAG_W+1)'(1);
    end
  end

  assign begin_replay_o = started_q && !busy && !(|fill_en_i);

  always_comb begin
    started_d = (started_q && !begin_replay_o) || (|alloc_e);
    locked_d  = locked_q;
    if (unlock_i)                    locked_d = 1'b0;
    else if (full || begin_replay_o) locked_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      started_q <= started_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: tb/tb_l1d_miss_cam_gen.sv
// tb_l1d_miss_cam_gen: directed scoreboard bench for l1d_miss_cam_gen.
// Driver queues expected fill/request/status/replay events; a monitor checks them.
module tb_l1d_miss_cam_gen;

  localparam int E  = 16;
  localparam int P  = 2;
  localparam int AW = 37;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    fill_en, fill_st, fill_ack, fill_match;
  logic [P*AW-1:0] fill_addr;
  logic [P*TW-1:0] fill_tag;
  logic            req_valid, req_ready, req_st;
  logic [AW-1:0]   req_addr;
  logic [TW-1:0]   req_tag, resp_tag;
  logic            resp_en, locked, begin_replay, unlock;
  logic [TW:0]     free_cnt;

  l1d_miss_cam_gen #(
    .ENTRIES(E), .PORTS(P), .ADDR_W(AW), .TAG_W(TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fill_en_i     (fill_en),
    .fill_addr_i   (fill_addr),
    .fill_st_i     (fill_st),
    .fill_ack_o    (fill_ack),
    .fill_match_o  (fill_match),
    .fill_tag_o    (fill_tag),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .req_addr_o    (req_addr),
    .req_tag_o     (req_tag),
    .req_st_o      (req_st),
    .resp_en_i     (resp_en),
    .resp_tag_i    (resp_tag),
    .free_cnt_o    (free_cnt),
    .locked_o      (locked),
    .begin_replay_o(begin_replay),
    .unlock_i      (unlock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          ack;
    logic          match;
    logic [TW-1:0] tag;
  } fexp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic          st;
  } rexp_t;

  typedef enum int {S_FREE, S_LOCK, S_RV, S_RADDR, S_RTAG, S_RST, S_ACK} sid_e;

  typedef struct {
    int          cyc;
    sid_e        id;
    logic [63:0] val;
  } sexp_t;

  fexp_t fq[$];
  rexp_t rq[$];
  sexp_t sq[$];
  int    pq[$];
  int    vectors = 0;
  int    errors  = 0;
  bit    mon_on  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    fill_en   = '0;
    fill_st   = '0;
    fill_addr = '0;
    req_ready = 1'b0;
    resp_en   = 1'b0;
    resp_tag  = '0;
    unlock    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic fill(input int p, input logic [AW-1:0] a, input logic s,
                      input logic ack, input logic m, input logic [TW-1:0] t);
    fill_en[p]            = 1'b1;
    fill_st[p]            = s;
    fill_addr[p*AW +: AW] = a;
    fq.push_back('{ack, m, t});
  endtask

  task automatic expect_s(input sid_e id, input logic [63:0] v);
    sq.push_back('{cyc, id, v});
  endtask

  task automatic expect_req(input logic [AW-1:0] a, input logic [TW-1:0] t,
                            input logic s);
    req_ready = 1'b1;
    rq.push_back('{a, t, s});
  endtask

  task automatic resp(input logic [TW-1:0] t);
    resp_en  = 1'b1;
    resp_tag = t;
  endtask

  function automatic logic [63:0] sget(input sid_e id);
    case (id)
      S_FREE:  return 64'(free_cnt);
      S_LOCK:  return 64'(locked);
      S_RV:    return 64'(req_valid);
      S_RADDR: return 64'(req_addr);
      S_RTAG:  return 64'(req_tag);
      S_RST:   return 64'(req_st);
      default: return 64'(fill_ack);
    endcase
  endfunction

  initial begin : mon
    sexp_t       e;
    fexp_t       f;
    rexp_t       r;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
          e   = sq.pop_front();
          act = sget(e.id);
          vectors++;
          if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s cyc %0d: got 0x%0h want 0x%0h",
                     e.id.name(), e.cyc, act, e.val);
          end
        end
        for (int p = 0; p < P; p++) begin
          if (fill_en[p]) begin
            vectors++;
            if (fq.size() == 0) begin
              errors++;
              $display("FAIL fill p%0d cyc %0d: no expectation", p, cyc);
            end else begin
              f = fq.pop_front();
              if (fill_ack[p] !== f.ack ||
                  (f.ack && (fill_match[p] !== f.match ||
                             fill_tag[p*TW +: TW] !== f.tag))) begin
                errors++;
                $display("FAIL fill p%0d cyc %0d: got ack%b m%b t%0d want ack%b m%b t%0d",
                         p, cyc, fill_ack[p], fill_match[p],
                         fill_tag[p*TW +: TW], f.ack, f.match, f.tag);
              end
            end
          end
        end
        if (req_valid === 1'b1 && req_ready === 1'b1) begin
          vectors++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL req cyc %0d: unexpected tag %0d", cyc, req_tag);
          end else begin
            r = rq.pop_front();
            if (req_addr !== r.addr || req_tag !== r.tag || req_st !== r.st) begin
              errors++;
              $display("FAIL req cyc %0d: got a%0h t%0d s%b want a%0h t%0d s%b",
                       cyc, req_addr, req_tag, req_st, r.addr, r.tag, r.st);
            end
          end
        end
        while (pq.size() > 0 && pq[0] < cyc) begin
          vectors++;
          errors++;
          $display("FAIL replay: got none want pulse at cyc %0d", pq[0]);
          void'(pq.pop_front());
        end
        if (begin_replay !== 1'b0) begin
          vectors++;
          if (pq.size() > 0 && pq[0] == cyc) begin
            void'(pq.pop_front());
          end else begin
            errors++;
            $display("FAIL replay cyc %0d: got %b want 0", cyc, begin_replay);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : drv
    rst       = 1'b1;
    fill_en   = '0;
    fill_st   = '0;
    fill_addr = '0;
    req_ready = 1'b0;
    resp_en   = 1'b0;
    resp_tag  = '0;
    unlock    = 1'b0;
    do_reset();
    mon_on = 1'b1;

    // reset state
    expect_s(S_FREE, 16);
    expect_s(S_LOCK, 0);
    expect_s(S_RV, 0);
    expect_s(S_ACK, 0);
    tick();

    // single fill, request visible next cycle
    fill(0, 'h100, 1'b0, 1, 0, 0);
    expect_s(S_FREE, 16);
    tick();
    expect_s(S_RV, 1);
    expect_s(S_RADDR, 'h100);
    expect_s(S_RTAG, 0);
    expect_s(S_FREE, 15);
    tick();
    do_reset();

    // same-cycle cross-port merge, one request
    fill(0, 'h2A0, 1'b0, 1, 0, 0);
    fill(1, 'h2A0, 1'b1, 1, 1, 0);
    tick();
    expect_s(S_RST, 1);
    expect_s(S_FREE, 15);
    expect_req('h2A0, 0, 1'b1);
    tick();
    expect_s(S_RV, 0);
    tick();
    do_reset();

    // merge into PEND entry during handshake; next free slot
    fill(0, 'h300, 1'b0, 1, 0, 0);
    tick();
    fill(0, 'h400, 1'b0, 1, 0, 1);
    fill(1, 'h300, 1'b1, 1, 1, 0);
    expect_req('h300, 0, 1'b1);
    tick();
    expect_s(S_RV, 1);
    expect_s(S_RADDR, 'h400);
    expect_s(S_RTAG, 1);
    expect_s(S_FREE, 14);
    tick();
    do_reset();

    // fill to capacity, overflow, lock
    for (int k = 0; k < 8; k++) begin
      fill(0, AW'('h1000 + 2*k), 1'b0, 1, 0, TW'(2*k));
      fill(1, AW'('h1000 + 2*k + 1), k[0], 1, 0, TW'(2*k + 1));
      if (k == 7) expect_s(S_FREE, 2);
      tick();
    end
    fill(0, 'h2000, 1'b0, 0, 0, 0);
    fill(1, 'h1003, 1'b1, 1, 1, 3);
    expect_s(S_FREE, 0);
    expect_s(S_LOCK, 0);
    tick();
    expect_s(S_LOCK, 1);
    fill(0, 'h1005, 1'b0, 0, 0, 0);
    fill(1, 'h3000, 1'b0, 0, 0, 0);
    tick();
    expect_s(S_LOCK, 1);
    expect_s(S_RV, 1);
    expect_s(S_RTAG, 0);
    tick();
    do_reset();

    // issue/resolve four misses, replay, lock, unlock
    fill(0, 'h10, 1'b0, 1, 0, 0);
    fill(1, 'h11, 1'b0, 1, 0, 1);
    tick();
    fill(0, 'h12, 1'b0, 1, 0, 2);
    fill(1, 'h13, 1'b1, 1, 0, 3);
    expect_req('h10, 0, 1'b0);
    tick();
    expect_req('h11, 1, 1'b0);
    resp(0);
    tick();
    expect_req('h12, 2, 1'b0);
    resp(1);
    tick();
    expect_req('h13, 3, 1'b1);
    resp(2);
    tick();
    resp(3);
    expect_s(S_FREE, 12);
    expect_s(S_RV, 0);
    tick();
    pq.push_back(cyc);
    expect_s(S_LOCK, 0);
    tick();
    expect_s(S_LOCK, 1);
    fill(0, 'h50, 1'b0, 0, 0, 0);
    resp(5);
    tick();
    unlock = 1'b1;
    fill(0, 'h60, 1'b0, 0, 0, 0);
    expect_s(S_LOCK, 1);
    expect_s(S_FREE, 12);
    tick();
    fill(0, 'h60, 1'b0, 1, 0, 0);
    expect_s(S_LOCK, 0);
    expect_s(S_FREE, 16);
    tick();
    expect_s(S_RV, 1);
    expect_s(S_RADDR, 'h60);
    tick();
    do_reset();

    // reset with four entries in WAIT, stale response
    fill(0, 'h20, 1'b0, 1, 0, 0);
    fill(1, 'h21, 1'b0, 1, 0, 1);
    tick();
    fill(0, 'h22, 1'b0, 1, 0, 2);
    fill(1, 'h23, 1'b0, 1, 0, 3);
    expect_req('h20, 0, 1'b0);
    tick();
    expect_req('h21, 1, 1'b0);
    tick();
    expect_req('h22, 2, 1'b0);
    tick();
    expect_req('h23, 3, 1'b0);
    tick();
    expect_s(S_FREE, 12);
    rst = 1'b1;
    tick();
    resp(2);
    expect_s(S_FREE, 16);
    expect_s(S_LOCK, 0);
    expect_s(S_RV, 0);
    tick();
    expect_s(S_FREE, 16);
    expect_s(S_RV, 0);
    tick();
    tick();

    @(negedge clk);
    #1;
    while (sq.size() > 0) begin
      errors++;
      $display("FAIL %s: got unchecked want checked", sq[0].id.name());
      void'(sq.pop_front());
    end
    if (fq.size() > 0) begin
      errors += fq.size();
      $display("FAIL fillq: got %0d left want 0", fq.size());
    end
    if (rq.size() > 0) begin
      errors += rq.size();
      $display("FAIL reqq: got %0d left want 0", rq.size());
    end
    if (pq.size() > 0) begin
      errors += pq.size();
      $display("FAIL replayq: got %0d left want 0", pq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
